key_debounce: RTL
=================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The module SHALL have parameter NUM_KEYS, default 2, giving the number of independent key channels.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), giving the required stable-sample count; legal range 2..2^24.
REQ-003 Port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port key_in, input, NUM_KEYS bits: raw asynchronous push-button levels, active-low (0 = pressed).
REQ-006 Port key_out, output, NUM_KEYS bits: debounced level, same polarity as key_in; feeds the PIO in_port directly.
REQ-007 Port key_press, output, NUM_KEYS bits: one-cycle pulse per channel on a debounced 1->0 transition.
REQ-008 Port key_release, output, NUM_KEYS bits: one-cycle pulse per channel on a debounced 0->1 transition.

Function
REQ-009 Each key_in bit SHALL pass through a 2-flop synchronizer (s1, s2); only s2 is used by the channel logic.
REQ-010 Each channel SHALL run an independent 4-state FSM: HIGH (stable released), WAIT_LOW, LOW (stable pressed), WAIT_HIGH.
REQ-011 HIGH -> WAIT_LOW when s2 = 0, loading count = 1; LOW -> WAIT_HIGH when s2 = 1, loading count = 1.
REQ-012 In WAIT_x, if s2 equals the candidate level and count = DEBOUNCE_CYCLES-1, the FSM SHALL enter the stable candidate state and update key_out on the same edge.
REQ-013 In WAIT_x, if s2 equals the candidate and count < DEBOUNCE_CYCLES-1, count SHALL increment by 1.
REQ-014 In WAIT_x, if s2 reverts to the old level, the FSM SHALL return to the old stable state, clear count, and leave key_out unchanged (glitch rejection).
REQ-015 Latency: for a clean step, key_out SHALL change on edge DEBOUNCE_CYCLES+2, counting the first edge that samples the new key_in level as edge 1.
REQ-016 key_press / key_release SHALL be registered and asserted for exactly one cycle, on the cycle following the key_out update.
REQ-017 The counter SHALL be $clog2(DEBOUNCE_CYCLES) bits, unsigned, never wrap, and hold 0 in the stable states.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on several keys SHALL produce simultaneous pulses.
REQ-019 key_press and key_release SHALL never both be high on one channel in the same cycle.

Reset
REQ-020 While reset is high, s1, s2 and key_out SHALL be all ones, FSMs SHALL be in HIGH, counters SHALL be 0, and key_press / key_release SHALL be 0.
REQ-021 Assertion of reset mid-debounce SHALL abort the count immediately, with no pulse generated.
REQ-022 After reset release with a key already held low, the press SHALL be detected normally per REQ-015.

Structure
REQ-023 The FSM state encodings (2-bit constants ST_HIGH, ST_WAIT_LOW, ST_LOW, ST_WAIT_HIGH) SHALL live in shared package key_debounce_pkg.
REQ-024 One channel (synchronizer, FSM, counter, pulse regs) SHALL be sub-module key_debounce_ch, instantiated NUM_KEYS times by a generate loop.

Verification (DEBOUNCE_CYCLES = 8, NUM_KEYS = 2)
REQ-025 Clean press: key_in[0] 1->0 at edge 1 and held -> key_out[0] = 0 at edge 10; key_press[0] high for one cycle after edge 10; key_release = 0.
REQ-026 Bounce: key_in[0] low 5 cycles, high 2 cycles, then low and held -> no pulse from the first low; key_out[0] falls 10 edges after the final low.
REQ-027 Release: from debounced LOW, key_in[1] 0->1 and held -> key_out[1] = 1 at edge 10; one key_release[1] pulse; key_press[1] stays 0.
REQ-028 Simultaneous: both keys fall on the same edge -> key_out = 2'b00 on the same edge; key_press = 2'b11 for one cycle.
REQ-029 Reset mid-count: reset pulsed 4 cycles into WAIT_LOW -> key_out = 2'b11 and no pulse; held-low key then debounced 10 edges after reset release.
REQ-030 Sub-threshold glitch: 7-cycle low pulse on key_in[0] -> key_out[0] stays 1 and no pulses.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// -----------------------------------------------------------------------------
// key_debounce_pkg
//
// Purpose:
//   Shared definitions for the push-button debouncer: the per-channel FSM
//   state encoding, the legal range of the debounce window and a helper that
//   sizes the stable-sample counter.
//
// Contents:
//   deb_state_t      - 2-bit channel state (ST_HIGH, ST_WAIT_LOW, ST_LOW,
//                      ST_WAIT_HIGH)
//   DEB_CYCLES_MIN   - smallest supported debounce window, in clock cycles
//   DEB_CYCLES_MAX   - largest supported debounce window, in clock cycles
//   deb_cnt_width()  - counter width for a given debounce window
// -----------------------------------------------------------------------------
package key_debounce_pkg;

    // Stable states and their "waiting for the other level" companions.
    // Bit 1 tracks the debounced level direction; bit 0 marks a pending
    // transition, which keeps the encoding easy to read on a waveform.
    typedef enum logic [1:0] {
        ST_HIGH      = 2'b00,  // stable released (key_out = 1)
        ST_WAIT_LOW  = 2'b01,  // released, counting consecutive low samples
        ST_LOW       = 2'b10,  // stable pressed (key_out = 0)
        ST_WAIT_HIGH = 2'b11   // pressed, counting consecutive high samples
    } deb_state_t;

    localparam int unsigned DEB_CYCLES_MIN = 2;
    localparam int unsigned DEB_CYCLES_MAX = 32'd1 << 24;

    // The counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 of the
    // window is enough. The floor of 1 bit keeps the vector legal even if
    // someone instantiates below the supported minimum.
    function automatic int unsigned deb_cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : key_debounce_pkg

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
//
// Purpose:
//   One debounced key channel: a two-flop synchronizer, a four-state
//   debounce FSM with a stable-sample counter, and registered one-cycle
//   press / release pulses.
//
// Ports:
//   i_clk      in   1  clock, all state on the rising edge
//   i_reset    in   1  asynchronous active-high reset
//   i_key      in   1  raw key level, active-low (0 = pressed), asynchronous
//   o_level    out  1  debounced key level, same polarity as i_key
//   o_press    out  1  one-cycle pulse after a debounced 1->0 transition
//   o_release  out  1  one-cycle pulse after a debounced 0->1 transition
//
// Timing:
//   A clean step on i_key first sampled on edge 1 moves o_level on edge
//   DEBOUNCE_CYCLES+2 (two synchronizer edges, then DEBOUNCE_CYCLES
//   consecutive matching samples). The matching pulse follows one edge later.
// -----------------------------------------------------------------------------
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_key,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int unsigned    CNT_W    = deb_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchronizer stages. Only r_s2 is allowed to reach the FSM.
    logic             r_s1;
    logic             r_s2;

    // Debounce FSM state, stable-sample counter and debounced level.
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_level;

    // Previous debounced level, used to build the registered pulses.
    logic             r_level_d;
    logic             r_press;
    logic             r_release;

    // -------------------------------------------------------------------------
    // Synchronizer, debounce FSM and pulse generation.
    //
    // NOTE: every register here is assigned with <= so that all of them
    // sample the pre-edge values; a blocking '=' on r_s1 would collapse the
    // two synchronizer stages into one.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            // NOTE: the synchronizer resets to the released level as well,
            // otherwise a reset-time zero in r_s1/r_s2 would look like a
            // press to the FSM right after reset is released.
            r_s1      <= 1'b1;
            r_s2      <= 1'b1;
            r_state   <= ST_HIGH;
            r_count   <= '0;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_s1 <= i_key;
            r_s2 <= r_s1;

            case (r_state)
                ST_HIGH: begin
                    // First low sample already counts toward the window.
                    if (!r_s2) begin
                        r_state <= ST_WAIT_LOW;
                        r_count <= CNT_ONE;
                    end
                end

                ST_WAIT_LOW: begin
                    if (r_s2) begin
                        // Bounce back to released: drop the partial count.
                        r_state <= ST_HIGH;
                        r_count <= '0;
                    end else if (r_count == CNT_LAST) begin
                        r_state <= ST_LOW;
                        r_count <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end

                ST_LOW: begin
                    if (r_s2) begin
                        r_state <= ST_WAIT_HIGH;
                        r_count <= CNT_ONE;
                    end
                end

                ST_WAIT_HIGH: begin
                    if (!r_s2) begin
                        // Bounce back to pressed: drop the partial count.
                        r_state <= ST_LOW;
                        r_count <= '0;
                    end else if (r_count == CNT_LAST) begin
                        r_state <= ST_HIGH;
                        r_count <= '0;
                        r_level <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end

                // NOTE: all four encodings are used, but the default keeps
                // the case complete so no tool ever infers hold logic here.
                default: begin
                    r_state <= ST_HIGH;
                    r_count <= '0;
                    r_level <= 1'b1;
                end
            endcase

            // Pulses fire one edge after the debounced level moves. r_level
            // changes by at most one step per edge, so press and release can
            // never be high together.
            r_level_d <= r_level;
            r_press   <= r_level_d & ~r_level;
            r_release <= ~r_level_d & r_level;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule : key_debounce_ch

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Purpose:
//   Multi-channel push-button debouncer. Each key bit gets its own fully
//   independent synchronizer, debounce FSM and pulse logic, so keys that move
//   together produce debounced edges and pulses on the same clock.
//
// Parameters:
//   NUM_KEYS         number of key channels
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a new level
//                    (1000000 = 20 ms at 50 MHz); supported range 2..2^24
//
// Ports:
//   clk          in   1         clock, all state on the rising edge
//   reset        in   1         asynchronous active-high reset
//   key_in       in   NUM_KEYS  raw key levels, active-low, asynchronous
//   key_out      out  NUM_KEYS  debounced levels, same polarity as key_in;
//                               registered, suitable for a PIO input port
//   key_press    out  NUM_KEYS  one-cycle pulse per debounced 1->0 edge
//   key_release  out  NUM_KEYS  one-cycle pulse per debounced 0->1 edge
// -----------------------------------------------------------------------------
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_release;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clk     (clk),
            .i_reset   (reset),
            .i_key     (key_in[g]),
            .o_level   (w_level[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g])
        );
    end

    assign key_out     = w_level;
    assign key_press   = w_press;
    assign key_release = w_release;

endmodule : key_debounce
